pcie_tl_fsm: RTL and testbench
==============================

// Module: pcie_tl_fsm
// PURPOSE
// - Main control FSM of the transaction layer; sits directly upstream of the counters block.
// - Sequences RESET -> INIT -> IDLE/ACTIVE, latches almost-empty/almost-full thresholds in INIT.
// - Drives the one-hot state[3:0] and idle consumed by counters. Flags sticky FIFO and config errors.
// PARAMETERS
// - NFIFO    5  number of monitored FIFOs (VC0, VC1, D0, D1, MF)
// - TH_W     3  threshold width (FIFO depth 8)
// - TH_LO_RST 1 reset value of th_low
// - TH_HI_RST 6 reset value of th_high
// PORTS
// - clk         in   1      system clock, all flops on posedge
// - reset_L     in   1      asynchronous, active-low reset
// - init        in   1      request (re)configuration; thresholds sampled while in INIT
// - th_low_in   in   TH_W   almost-empty threshold to load
// - th_high_in  in   TH_W   almost-full threshold to load
// - fifo_empty  in   NFIFO  per-FIFO empty flags
// - fifo_error  in   NFIFO  per-FIFO overflow/underflow pulses
// - state       out  4      registered one-hot: RESET=0001 INIT=0010 IDLE=0100 ACTIVE=1000, ERROR=0000
// - next_state  out  4      combinational next state, same encoding
// - idle        out  1      registered; 1 only in IDLE with all FIFOs empty
// - th_low      out  TH_W   latched almost-empty threshold
// - th_high     out  TH_W   latched almost-full threshold
// - error_out   out  NFIFO  sticky OR of fifo_error, per FIFO
// - cfg_error   out  1      sticky: thresholds loaded with th_low >= th_high
// BEHAVIOUR
// - reset_L=0 (async): state=RESET, idle=0, error_out=0, cfg_error=0, th_low=TH_LO_RST, th_high=TH_HI_RST.
// - All transitions take effect on the posedge after the cause; state == registered next_state.
// - Transition priority, highest first: reset_L -> fifo_error!=0 -> init -> per-state rule.
// - RESET: next=INIT unconditionally (first edge after reset_L release).
// - INIT: th_low<=th_low_in, th_high<=th_high_in every cycle. Leave when init=0:
//     th_low_in < th_high_in -> IDLE; else -> ERROR with cfg_error<=1 (thresholds still loaded).
// - IDLE: any fifo_empty=0 -> ACTIVE; else stay. init=1 -> INIT.
// - ACTIVE: &fifo_empty -> IDLE; else stay. init=1 -> INIT.
// - Any state but RESET: fifo_error!=0 -> ERROR, error_out <= error_out | fifo_error same edge.
// - ERROR: absorbing; init and fifo activity ignored, error_out keeps accumulating; exit only by reset_L.
// - Thresholds hold their value outside INIT; init re-entry overwrites them.
// - idle <= (next_state==IDLE) && &fifo_empty, so idle aligns with state, no extra latency.
// - fifo_error in RESET state is ignored (FIFOs not yet configured).
// - Simultaneous init and fifo_error: ERROR wins; thresholds not loaded that edge.
// - Reset asserted mid-ACTIVE: immediate return to reset values, no clock required.
// - next_state is a pure function of state and inputs; no latches; default branch -> ERROR.
// STRUCTURE
// - Shared package/include pcie_tl_pkg: state encodings ST_RESET/ST_INIT/ST_IDLE/ST_ACTIVE/ST_ERROR,
//   STATE_W=4, NFIFO, TH_W; counters and FIFOs import the same encodings.
// - One sub-module: pcie_tl_thresh_regs (threshold load/hold registers + th_low<th_high compare).
// - Top: next-state comb block, state register, idle register, sticky error register.
// TESTING
// - Reset, release, init=0, all empty -> state 0001, then 0010, then 0100 with idle=1.
// - INIT with init=1, th_low_in=2, th_high_in=5, drop init -> IDLE, th_low=2, th_high=5, cfg_error=0.
// - INIT with th_low_in=5, th_high_in=5 -> state=0000, cfg_error=1, thresholds 5/5.
// - IDLE, fifo_empty=5'b11101 -> next edge ACTIVE (1000), idle=0; fifo_empty=5'b11111 -> IDLE, idle=1.
// - ACTIVE, fifo_error=5'b00100 one cycle then init=1 -> ERROR stays, error_out=5'b00100;
//   later fifo_error=5'b00001 -> error_out=5'b00101.
// - reset_L low mid-clock in ACTIVE -> state=0001, error_out=0, th 1/6 before next posedge.

Source files
------------

// File: rtl/pcie_tl_pkg.sv
// Shared transaction-layer encodings and sizes; the counters and FIFO blocks import
// this same package so that all of them agree on the state encoding.
package pcie_tl_pkg;
    localparam int STATE_W = 4;
    localparam int NFIFO   = 5;
    localparam int TH_W    = 3;

    localparam logic [TH_W-1:0] TH_LO_RST = 3'd1;
    localparam logic [TH_W-1:0] TH_HI_RST = 3'd6;

    // One-hot for the live states; ERROR is the all-zero code.
    typedef enum logic [STATE_W-1:0] {
        ST_ERROR  = 4'b0000,
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } tl_state_e;
endpackage

// File: rtl/pcie_tl_fsm_if.sv
// Control/status bundle between the transaction-layer FSM and its environment.
interface pcie_tl_fsm_if;
    import pcie_tl_pkg::*;

    logic             init;
    logic [TH_W-1:0]  th_low_in;
    logic [TH_W-1:0]  th_high_in;
    logic [NFIFO-1:0] fifo_empty;
    logic [NFIFO-1:0] fifo_error;
    tl_state_e        state;
    tl_state_e        next_state;
    logic             idle;
    logic [TH_W-1:0]  th_low;
    logic [TH_W-1:0]  th_high;
    logic [NFIFO-1:0] error_out;
    logic             cfg_error;

    modport master (
        output init, th_low_in, th_high_in, fifo_empty, fifo_error,
        input  state, next_state, idle, th_low, th_high, error_out, cfg_error
    );

    modport slave (
        input  init, th_low_in, th_high_in, fifo_empty, fifo_error,
        output state, next_state, idle, th_low, th_high, error_out, cfg_error
    );
endinterface

// File: rtl/pcie_tl_thresh_regs.sv
// Almost-empty/almost-full threshold registers plus the low<high sanity compare
// on the incoming values (the ones that get latched on the same edge).
module pcie_tl_thresh_regs
    import pcie_tl_pkg::*;
(
    input  logic            clk,
    input  logic            reset_L,
    input  logic            load,
    input  logic [TH_W-1:0] th_low_in,
    input  logic [TH_W-1:0] th_high_in,
    output logic [TH_W-1:0] th_low,
    output logic [TH_W-1:0] th_high,
    output logic            th_ok
);
    assign th_ok = th_low_in < th_high_in;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            th_low  <= TH_LO_RST;
            th_high <= TH_HI_RST;
        end else if (load) begin
            th_low  <= th_low_in;
            th_high <= th_high_in;
        end
    end
endmodule

// File: rtl/pcie_tl_fsm.sv
// Transaction-layer control FSM: RESET -> INIT -> IDLE/ACTIVE, absorbing ERROR,
// with threshold latching, registered idle and sticky FIFO/config error flags.
module pcie_tl_fsm
    import pcie_tl_pkg::*;
(
    input  logic         clk,
    input  logic         reset_L,
    pcie_tl_fsm_if.slave bus
);
    tl_state_e        state_q, nxt;
    logic             idle_q, cfg_q, cfg_set, th_load, th_ok;
    logic [NFIFO-1:0] err_q;
    logic             any_err, all_empty;

    assign any_err   = |bus.fifo_error;
    assign all_empty = &bus.fifo_empty;

    // Thresholds follow the inputs for every INIT cycle, except an edge that
    // is diverted to ERROR by a FIFO error.
    assign th_load = (state_q == ST_INIT) && !any_err;

    always_comb begin
        nxt     = ST_ERROR;
        cfg_set = 1'b0;
        case (state_q)
            ST_RESET: nxt = ST_INIT;
            ST_ERROR: nxt = ST_ERROR;
            ST_INIT, ST_IDLE, ST_ACTIVE: begin
                if (any_err)
                    nxt = ST_ERROR;
                else if (bus.init)
                    nxt = ST_INIT;
                else if (state_q == ST_INIT) begin
                    nxt     = th_ok ? ST_IDLE : ST_ERROR;
                    cfg_set = !th_ok;
                end else
                    nxt = all_empty ? ST_IDLE : ST_ACTIVE;
            end
            default: nxt = ST_ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_RESET;
            idle_q  <= 1'b0;
            err_q   <= '0;
            cfg_q   <= 1'b0;
        end else begin
            state_q <= nxt;
            idle_q  <= (nxt == ST_IDLE) && all_empty;
            // FIFOs are unconfigured in RESET, so their error pulses are not recorded.
            if (state_q != ST_RESET)
                err_q <= err_q | bus.fifo_error;
            if (cfg_set)
                cfg_q <= 1'b1;
        end
    end

    pcie_tl_thresh_regs u_thresh (
        .clk        (clk),
        .reset_L    (reset_L),
        .load       (th_load),
        .th_low_in  (bus.th_low_in),
        .th_high_in (bus.th_high_in),
        .th_low     (bus.th_low),
        .th_high    (bus.th_high),
        .th_ok      (th_ok)
    );

    assign bus.state      = state_q;
    assign bus.next_state = nxt;
    assign bus.idle       = idle_q;
    assign bus.error_out  = err_q;
    assign bus.cfg_error  = cfg_q;
endmodule

// File: tb/tb_pcie_tl_fsm.sv
// Bench for pcie_tl_fsm: directed scenarios then randomized traffic, all checked
// against a behavioural model of the state rules.
module tb_pcie_tl_fsm;
    logic clk = 1'b0;
    logic reset_L = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    pcie_tl_fsm_if bus ();

    pcie_tl_fsm dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Model: M_RST/M_INIT/M_IDLE/M_ACT/M_ERR as plain integers.
    localparam int M_RST = 0, M_INIT = 1, M_IDLE = 2, M_ACT = 3, M_ERR = 4;
    int         m_st, m_nx;
    logic [2:0] m_lo, m_hi;
    logic [4:0] m_err;
    logic       m_cfg, m_idle;

    function automatic logic [3:0] enc(input int s);
        case (s)
            M_RST:   return 4'b0001;
            M_INIT:  return 4'b0010;
            M_IDLE:  return 4'b0100;
            M_ACT:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".state"},   32'(bus.state),     32'(enc(m_st)));
        chk({tag, ".idle"},    32'(bus.idle),      32'(m_idle));
        chk({tag, ".th_low"},  32'(bus.th_low),    32'(m_lo));
        chk({tag, ".th_high"}, 32'(bus.th_high),   32'(m_hi));
        chk({tag, ".err"},     32'(bus.error_out), 32'(m_err));
        chk({tag, ".cfg"},     32'(bus.cfg_error), 32'(m_cfg));
    endtask

    task automatic model_reset();
        m_st = M_RST; m_lo = 3'd1; m_hi = 3'd6; m_err = '0; m_cfg = 0; m_idle = 0;
    endtask

    // Drive one cycle of inputs, check next_state, clock, then check everything.
    task automatic tick(input string tag, input logic in_init, input logic [2:0] lo,
                        input logic [2:0] hi, input logic [4:0] emp, input logic [4:0] fe);
        bit all_e, cfg_now;
        bus.init = in_init; bus.th_low_in = lo; bus.th_high_in = hi;
        bus.fifo_empty = emp; bus.fifo_error = fe;
        all_e = (emp == 5'h1f);
        cfg_now = 0;
        if (m_st == M_RST)      m_nx = M_INIT;
        else if (m_st == M_ERR) m_nx = M_ERR;
        else if (fe != 0)       m_nx = M_ERR;
        else if (in_init)       m_nx = M_INIT;
        else if (m_st == M_INIT) begin
            m_nx = (lo < hi) ? M_IDLE : M_ERR;
            cfg_now = !(lo < hi);
        end else
            m_nx = all_e ? M_IDLE : M_ACT;
        #1;
        chk({tag, ".next"}, 32'(bus.next_state), 32'(enc(m_nx)));
        @(posedge clk);
        #1;
        if (m_st == M_INIT && fe == 0) begin m_lo = lo; m_hi = hi; end
        if (m_st != M_RST) m_err = m_err | fe;
        if (cfg_now) m_cfg = 1;
        m_idle = (m_nx == M_IDLE) && all_e;
        m_st = m_nx;
        chk_all(tag);
    endtask

    // Asynchronous reset in the middle of a clock phase; values must settle without an edge.
    task automatic do_reset(input string tag);
        reset_L = 1'b0;
        #1;
        model_reset();
        chk_all(tag);
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    initial begin
        bus.init = 0; bus.th_low_in = 0; bus.th_high_in = 0;
        bus.fifo_empty = '1; bus.fifo_error = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("rst0");
        @(negedge clk);
        reset_L = 1'b1;

        // Bring-up to IDLE.
        tick("up_init", 0, 3'd1, 3'd6, 5'h1f, 5'h00);
        tick("up_idle", 0, 3'd1, 3'd6, 5'h1f, 5'h00);
        // Reconfigure to 2/5.
        tick("cfg_a", 1, 3'd2, 3'd5, 5'h1f, 5'h00);
        tick("cfg_b", 1, 3'd2, 3'd5, 5'h1f, 5'h00);
        tick("cfg_c", 0, 3'd2, 3'd5, 5'h1f, 5'h00);
        // IDLE <-> ACTIVE.
        tick("act",   0, 3'd0, 3'd0, 5'b11101, 5'h00);
        tick("idle",  0, 3'd0, 3'd0, 5'b11111, 5'h00);
        tick("act2",  0, 3'd0, 3'd0, 5'b11101, 5'h00);
        // FIFO error, ERROR absorbing and accumulating.
        tick("ferr",  0, 3'd0, 3'd0, 5'b11101, 5'b00100);
        tick("eini",  1, 3'd3, 3'd4, 5'b11111, 5'h00);
        tick("eacc",  0, 3'd0, 3'd0, 5'b11111, 5'b00001);
        do_reset("rst_err");
        // Bad thresholds 5/5.
        tick("bad_i", 0, 3'd5, 3'd5, 5'h1f, 5'h00);
        tick("bad",   0, 3'd5, 3'd5, 5'h1f, 5'h00);
        do_reset("rst_cfg");
        // Simultaneous init + fifo_error inside INIT: ERROR wins, no load.
        tick("sim_i", 1, 3'd1, 3'd6, 5'h1f, 5'h00);
        tick("sim_h", 1, 3'd0, 3'd7, 5'h1f, 5'h00);
        tick("sim",   1, 3'd3, 3'd2, 5'h1f, 5'b10000);
        do_reset("rst_sim");
        // fifo_error in RESET ignored; then reset mid-ACTIVE.
        tick("rerr",  0, 3'd1, 3'd6, 5'h1f, 5'b01000);
        tick("ma_i",  0, 3'd2, 3'd7, 5'h1f, 5'h00);
        tick("ma_a",  0, 3'd2, 3'd7, 5'h0f, 5'h00);
        do_reset("rst_act");

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0)
                do_reset("r_rst");
            else
                tick("rnd",
                     ($urandom_range(0, 7) == 0),
                     3'($urandom), 3'($urandom),
                     ($urandom_range(0, 1) == 0) ? 5'h1f : 5'($urandom),
                     ($urandom_range(0, 59) == 0) ? 5'($urandom_range(1, 31)) : 5'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
